// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic [3:0] WE_READ = 4'b0000;

  // Widened compare so a depth of 2^30 words does not wrap to zero.
  function automatic logic addr_in_range(input logic [29:0] addr, input int unsigned size);
    return ({2'b00, addr} < 32'(size));
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for the two requesters; RAM_ARB_FIXED_PRIO_EN makes requester 0
// win every tie, otherwise ties go to the requester that did not win last time.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] stb,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    valid = |stb;
    grant = REQ0;
    case (stb)
      2'b01:   grant = REQ0;
      2'b10:   grant = REQ1;
`ifdef RAM_ARB_FIXED_PRIO_EN
      2'b11:   grant = REQ0;
`else
      2'b11:   grant = ~last_grant;
`endif
      default: grant = REQ0;
    endcase
  end

endmodule

// File: rtl/ram_arb2.sv
// Two-requester arbiter sharing one port of a write-first block RAM with 1-cycle read latency.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (requester 0 always wins ties).
//
// state | meaning
// IDLE  | sample strobes, latch winner's request onto the RAM bus
// ISSUE | RAM port enabled; RAM samples the request at the end of this cycle
// RESP  | RAM read data valid; ack/err/data presented to the owner
module ram_arb2
  import ram_arb_pkg::*;
#(
  parameter int SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        r0_stb_i,
  input  logic [3:0]  r0_we_i,
  input  logic [29:0] r0_addr_i,
  input  logic [31:0] r0_data_i,
  output logic [31:0] r0_data_o,
  output logic        r0_ack_o,
  output logic        r0_err_o,

  input  logic        r1_stb_i,
  input  logic [3:0]  r1_we_i,
  input  logic [29:0] r1_addr_i,
  input  logic [31:0] r1_data_i,
  output logic [31:0] r1_data_o,
  output logic        r1_ack_o,
  output logic        r1_err_o,

  output logic        ram_en_o,
  output logic [3:0]  ram_we_o,
  output logic [29:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        err_q;

  logic        win;
  logic        win_vld;
  logic [3:0]  win_we;
  logic [29:0] win_addr;
  logic [31:0] win_data;
  logic        win_in_range;

  ram_arb_pick u_pick (
    .stb        ({r1_stb_i, r0_stb_i}),
    .last_grant (last_grant),
    .grant      (win),
    .valid      (win_vld)
  );

  always_comb begin
    win_we   = r0_we_i;
    win_addr = r0_addr_i;
    win_data = r0_data_i;
    if (win == REQ1) begin
      win_we   = r1_we_i;
      win_addr = r1_addr_i;
      win_data = r1_data_i;
    end
  end

  assign win_in_range = addr_in_range(win_addr, SIZE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      owner      <= REQ0;
      last_grant <= REQ1;
      err_q      <= 1'b0;
      ram_en_o   <= 1'b0;
      ram_we_o   <= WE_READ;
      ram_addr_o <= '0;
      ram_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            owner      <= win;
            last_grant <= win;
            ram_we_o   <= win_we;
            ram_addr_o <= win_addr;
            ram_data_o <= win_data;
            // Out-of-range requests never touch the RAM; the err latch answers them.
            ram_en_o   <= win_in_range;
            err_q      <= ~win_in_range;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en_o <= 1'b0;
          ram_we_o <= WE_READ;
          state    <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic resp;
  assign resp = (state == RESP);

  assign r0_ack_o  = resp & (owner == REQ0);
  assign r1_ack_o  = resp & (owner == REQ1);
  assign r0_err_o  = r0_ack_o & err_q;
  assign r1_err_o  = r1_ack_o & err_q;
  assign r0_data_o = (r0_ack_o && !err_q) ? ram_data_i : 32'h0;
  assign r1_data_o = (r1_ack_o && !err_q) ? ram_data_i : 32'h0;

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2 with a behavioural write-first byte-lane RAM.
module tb_ram_arb2;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        r0_stb_i, r1_stb_i;
  logic [3:0]  r0_we_i, r1_we_i;
  logic [29:0] r0_addr_i, r1_addr_i;
  logic [31:0] r0_data_i, r1_data_i;
  logic [31:0] r0_data_o, r1_data_o;
  logic        r0_ack_o, r1_ack_o, r0_err_o, r1_err_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [29:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ram_arb2 #(.SIZE(1024)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .r0_stb_i   (r0_stb_i),
    .r0_we_i    (r0_we_i),
    .r0_addr_i  (r0_addr_i),
    .r0_data_i  (r0_data_i),
    .r0_data_o  (r0_data_o),
    .r0_ack_o   (r0_ack_o),
    .r0_err_o   (r0_err_o),
    .r1_stb_i   (r1_stb_i),
    .r1_we_i    (r1_we_i),
    .r1_addr_i  (r1_addr_i),
    .r1_data_i  (r1_data_i),
    .r1_data_o  (r1_data_o),
    .r1_ack_o   (r1_ack_o),
    .r1_err_o   (r1_err_o),
    .ram_en_o   (ram_en_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i)
  );

  // RAM model: contents survive reset, preloaded on the first edge.
  logic [31:0] mem [0:1023];
  logic        loaded = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (!loaded) begin
      loaded     <= 1'b1;
      mem[0]     <= 32'h0BADF00D;
      mem[3]     <= 32'h00000000;
      mem[5]     <= 32'hDEADBEEF;
      mem[7]     <= 32'h11223344;
      mem[9]     <= 32'h00000000;
      mem[1023]  <= 32'hA5A55A5A;
    end else if (ram_en_o) begin
      mem[ram_addr_o[9:0]] <= merge(mem[ram_addr_o[9:0]], ram_data_o, ram_we_o);
      ram_data_i           <= merge(mem[ram_addr_o[9:0]], ram_data_o, ram_we_o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic [3:0]  we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic idle_inputs();
    r0_stb_i = 1'b0; r0_we_i = 4'h0; r0_addr_i = '0; r0_data_i = '0;
    r1_stb_i = 1'b0; r1_we_i = 4'h0; r1_addr_i = '0; r1_data_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic do_vec(input int idx, input vec_t v);
    logic ack_own, ack_oth, err_own;
    logic [31:0] data_own;
    @(negedge clk_i);
    chk($sformatf("vec%0d_idle_acks", idx), {30'h0, r1_ack_o, r0_ack_o}, 32'h0);
    if (v.req) begin
      r1_stb_i = 1'b1; r1_we_i = v.we; r1_addr_i = v.addr; r1_data_i = v.wdata;
    end else begin
      r0_stb_i = 1'b1; r0_we_i = v.we; r0_addr_i = v.addr; r0_data_i = v.wdata;
    end
    @(negedge clk_i);
    chk($sformatf("vec%0d_ram_en_issue", idx), {31'h0, ram_en_o}, {31'h0, ~v.exp_err});
    if (!v.exp_err) begin
      chk($sformatf("vec%0d_ram_addr", idx), {2'b0, ram_addr_o}, {2'b0, v.addr});
      chk($sformatf("vec%0d_ram_we", idx), {28'h0, ram_we_o}, {28'h0, v.we});
    end
    @(negedge clk_i);
    ack_own  = v.req ? r1_ack_o  : r0_ack_o;
    ack_oth  = v.req ? r0_ack_o  : r1_ack_o;
    err_own  = v.req ? r1_err_o  : r0_err_o;
    data_own = v.req ? r1_data_o : r0_data_o;
    chk($sformatf("vec%0d_ack", idx), {31'h0, ack_own}, 32'h1);
    chk($sformatf("vec%0d_other_ack", idx), {31'h0, ack_oth}, 32'h0);
    chk($sformatf("vec%0d_err", idx), {31'h0, err_own}, {31'h0, v.exp_err});
    chk($sformatf("vec%0d_ram_en_resp", idx), {31'h0, ram_en_o}, 32'h0);
    if (v.chk_data) chk($sformatf("vec%0d_data", idx), data_own, v.exp_data);
    idle_inputs();
  endtask

  task automatic contend(input string tag, input logic [29:0] a0, input logic [29:0] a1,
                         input int ncyc, input logic [31:0] d0, input logic [31:0] d1);
    logic e0, e1;
    @(negedge clk_i);
    r0_stb_i = 1'b1; r0_we_i = 4'h0; r0_addr_i = a0;
    r1_stb_i = 1'b1; r1_we_i = 4'h0; r1_addr_i = a1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk_i);
`ifdef RAM_ARB_FIXED_PRIO_EN
      e0 = (k % 3 == 2);
      e1 = 1'b0;
`else
      e0 = (k % 6 == 2);
      e1 = (k % 6 == 5);
`endif
      chk($sformatf("%s_r0_ack_c%0d", tag, k), {31'h0, r0_ack_o}, {31'h0, e0});
      chk($sformatf("%s_r1_ack_c%0d", tag, k), {31'h0, r1_ack_o}, {31'h0, e1});
      if (e0) chk($sformatf("%s_r0_data_c%0d", tag, k), r0_data_o, d0);
      if (e1) chk($sformatf("%s_r1_data_c%0d", tag, k), r1_data_o, d1);
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 4'h0, 30'd5,          32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 4'h2, 30'd7,          32'h0000AB00, 1'b0, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 4'h0, 30'd7,          32'h0,        1'b1, 32'h1122AB44, 1'b0};
    vecs[3] = '{1'b0, 4'hF, 30'd9,          32'h12345678, 1'b0, 32'h0,        1'b0};
    vecs[4] = '{1'b1, 4'h0, 30'd9,          32'h0,        1'b1, 32'h12345678, 1'b0};
    vecs[5] = '{1'b0, 4'hF, 30'd1024,       32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 4'h0, 30'd0,          32'h0,        1'b1, 32'h0BADF00D, 1'b0};
    vecs[7] = '{1'b1, 4'h0, 30'd1023,       32'h0,        1'b1, 32'hA5A55A5A, 1'b0};
    vecs[8] = '{1'b1, 4'h0, 30'h3FFFFFFF,   32'h0,        1'b1, 32'h0,        1'b1};
    vecs[9] = '{1'b0, 4'h9, 30'd9,          32'hAA0000BB, 1'b0, 32'h0,        1'b0};

    idle_inputs();
    rst_n_i = 1'b0;
    do_reset();

    chk("reset_ram_en",   {31'h0, ram_en_o}, 32'h0);
    chk("reset_ram_we",   {28'h0, ram_we_o}, 32'h0);
    chk("reset_ram_addr", {2'b0, ram_addr_o}, 32'h0);
    chk("reset_ram_data", ram_data_o, 32'h0);
    chk("reset_ack_err",  {28'h0, r1_err_o, r0_err_o, r1_ack_o, r0_ack_o}, 32'h0);

    for (int i = 0; i < 10; i++) do_vec(i, vecs[i]);
    do_vec(10, '{1'b0, 4'h0, 30'd9, 32'h0, 1'b1, 32'hAA3456BB, 1'b0});

    do_reset();
    contend("contend", 30'd5, 30'd7, 12, 32'hDEADBEEF, 32'h1122AB44);

    // Reset lands on the edge that ends ISSUE: write commits, no ack.
    do_reset();
    @(negedge clk_i);
    r1_stb_i = 1'b1; r1_we_i = 4'hF; r1_addr_i = 30'd3; r1_data_i = 32'hCAFEF00D;
    @(negedge clk_i);
    chk("midrst_ram_en_issue", {31'h0, ram_en_o}, 32'h1);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_r1_ack_a", {31'h0, r1_ack_o}, 32'h0);
    chk("midrst_ram_en",   {31'h0, ram_en_o}, 32'h0);
    chk("midrst_ram_addr", {2'b0, ram_addr_o}, 32'h0);
    idle_inputs();
    @(negedge clk_i);
    chk("midrst_r1_ack_b", {31'h0, r1_ack_o}, 32'h0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_r1_ack_c", {31'h0, r1_ack_o}, 32'h0);
    contend("postrst", 30'd3, 30'd5, 2, 32'hCAFEF00D, 32'hDEADBEEF);
    @(negedge clk_i);
    chk("postrst_acks_low", {30'h0, r1_ack_o, r0_ack_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
